// File: rtl/mu0_mem_arb.sv
// mu0_mem_arb: shares the single MU0 memory bus between the core (port 0)
// and a DMA/debug loader (port 1). One requester is granted at a time with
// round-robin priority. Each grant runs a fixed WAIT_CYCLES memory access,
// followed by a one-cycle ack carrying registered read data.
//
// Ports
//   clk, reset             system clock; asynchronous active-low reset
//   m0_* / m1_*            requester ports: req, rnw, addr, wdata in;
//                          rdata, ack out
//   mem_addr/wdata/cs/we   memory-side outputs
//   mem_rdata              memory read data, valid in the last mem_cs cycle
//   gnt                    one-hot owner (bit 0 = port 0), 00 when idle
//   busy                   high while an access or its ack is in flight
//
// state  | meaning
// IDLE   | sample requests, latch the winner and start an access
// ACCESS | mem_cs held while the wait counter runs down to 0
// DONE   | one-cycle ack to the winner, then back to IDLE
module mu0_mem_arb #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_rnw,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_rnw,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_cs,
    output logic              mem_we,
    output logic [1:0]        gnt,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic              r_lg, w_lg_nxt;
    logic [3:0]        r_cnt, w_cnt_nxt;
    logic              r_rnw, w_rnw_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [1:0]        r_gnt, w_gnt_nxt;
    logic              r_mem_cs, w_mem_cs_nxt;
    logic              r_mem_we, w_mem_we_nxt;
    logic              r_busy, w_busy_nxt;
    logic [DATA_W-1:0] r_m0_rdata, w_m0_rdata_nxt;
    logic [DATA_W-1:0] r_m1_rdata, w_m1_rdata_nxt;
    logic              r_m0_ack, w_m0_ack_nxt;
    logic              r_m1_ack, w_m1_ack_nxt;
    logic              w_pick1;
    logic              w_sel_rnw;

    // r_lg = 1 means port 1 was granted last, so port 0 wins a tie.
    assign w_pick1   = m1_req & (~m0_req | ~r_lg);
    assign w_sel_rnw = w_pick1 ? m1_rnw : m0_rnw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_lg       <= 1'b1;
            r_cnt      <= '0;
            r_rnw      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_gnt      <= 2'b00;
            r_mem_cs   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_busy     <= 1'b0;
            r_m0_rdata <= '0;
            r_m1_rdata <= '0;
            r_m0_ack   <= 1'b0;
            r_m1_ack   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_lg       <= w_lg_nxt;
            r_cnt      <= w_cnt_nxt;
            r_rnw      <= w_rnw_nxt;
            r_addr     <= w_addr_nxt;
            r_wdata    <= w_wdata_nxt;
            r_gnt      <= w_gnt_nxt;
            r_mem_cs   <= w_mem_cs_nxt;
            r_mem_we   <= w_mem_we_nxt;
            r_busy     <= w_busy_nxt;
            r_m0_rdata <= w_m0_rdata_nxt;
            r_m1_rdata <= w_m1_rdata_nxt;
            r_m0_ack   <= w_m0_ack_nxt;
            r_m1_ack   <= w_m1_ack_nxt;
        end
    end

    // Every output is a register; this block computes their next values so
    // that mem_cs/gnt/busy rise on the same edge that samples the request.
    always_comb begin
        w_state_nxt    = r_state;
        w_lg_nxt       = r_lg;
        w_cnt_nxt      = r_cnt;
        w_rnw_nxt      = r_rnw;
        w_addr_nxt     = r_addr;
        w_wdata_nxt    = r_wdata;
        w_gnt_nxt      = r_gnt;
        w_mem_cs_nxt   = r_mem_cs;
        w_mem_we_nxt   = r_mem_we;
        w_busy_nxt     = r_busy;
        w_m0_rdata_nxt = r_m0_rdata;
        w_m1_rdata_nxt = r_m1_rdata;
        w_m0_ack_nxt   = 1'b0;
        w_m1_ack_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    w_state_nxt  = ACCESS;
                    w_lg_nxt     = w_pick1;
                    w_cnt_nxt    = CNT_LOAD;
                    w_rnw_nxt    = w_sel_rnw;
                    w_addr_nxt   = w_pick1 ? m1_addr : m0_addr;
                    w_wdata_nxt  = w_pick1 ? m1_wdata : m0_wdata;
                    w_gnt_nxt    = w_pick1 ? 2'b10 : 2'b01;
                    w_mem_cs_nxt = 1'b1;
                    w_mem_we_nxt = ~w_sel_rnw;
                    w_busy_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = DONE;
                    w_mem_cs_nxt = 1'b0;
                    w_mem_we_nxt = 1'b0;
                    if (r_rnw && r_gnt[0]) w_m0_rdata_nxt = mem_rdata;
                    if (r_rnw && r_gnt[1]) w_m1_rdata_nxt = mem_rdata;
                    w_m0_ack_nxt = r_gnt[0];
                    w_m1_ack_nxt = r_gnt[1];
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = 2'b00;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign m0_rdata  = r_m0_rdata;
    assign m0_ack    = r_m0_ack;
    assign m1_rdata  = r_m1_rdata;
    assign m1_ack    = r_m1_ack;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_cs    = r_mem_cs;
    assign mem_we    = r_mem_we;
    assign gnt       = r_gnt;
    assign busy      = r_busy;

endmodule

// File: doc/mu0_mem_arb.md
# mu0_mem_arb

Two-port memory arbiter that shares the single 16-bit MU0 memory bus between the MU0 core (port 0) and a DMA/debug loader (port 1). It sits between the core's memory interface (addr, data, memrq, rnw) and the memory array. It grants one requester at a time using round-robin priority, runs a fixed-length multi-cycle memory access, and returns a one-cycle acknowledge with registered read data.

## Interface
- WAIT_CYCLES, 1: number of cycles mem_cs is held per access; legal range 1..15.
- ADDR_W, 12: address width.
- DATA_W, 16: data width.

- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- m0_req  input  1  port 0 (core) request level.
- m0_rnw  input  1  port 0 direction: 1 = read, 0 = write.
- m0_addr  input  ADDR_W  port 0 address.
- m0_wdata  input  DATA_W  port 0 write data.
- m0_rdata  output  DATA_W  port 0 read data; valid while m0_ack is high.
- m0_ack  output  1  port 0 completion pulse.
- m1_req, m1_rnw, m1_addr, m1_wdata, m1_rdata, m1_ack: same as port 0, for port 1 (DMA).
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_rdata  input  DATA_W  memory read data; valid in the last mem_cs cycle.
- mem_cs  output  1  memory select.
- mem_we  output  1  memory write enable; asserted only together with mem_cs.
- gnt  output  2  one-hot current owner; 00 when idle.
- busy  output  1  high in ACCESS and DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE. Cycle counter width: 4 bits.
- IDLE: requests are sampled on the clock edge.
  - If any request is high, latch the winner's rnw, addr and wdata into the memory-side registers.
  - Set gnt, load the counter with WAIT_CYCLES-1, and go to ACCESS.
  - If no request is high, stay in IDLE.
- Arbitration is round-robin on a last-grant bit (lg):
  - If only one port requests, that port wins.
  - If both request, the port that was not last granted wins.
  - lg updates on each grant.
- ACCESS:
  - mem_cs = 1; mem_we = !latched rnw; mem_addr and mem_wdata come from the latched values.
  - The counter decrements each cycle.
  - When the counter is 0, capture mem_rdata into the winner's rdata register (reads only) and go to DONE.
- DONE:
  - The winner's ack = 1 for exactly one cycle; mem_cs = 0.
  - The non-winner's ack stays 0, and its rdata register keeps its previous value.
  - Next state is IDLE unconditionally.
- Requesters hold req, rnw, addr and wdata stable from assertion until ack.
  - If req is still high in the IDLE cycle after ack, that is a new request.
  - A request that drops before it is granted is simply not serviced.
- Inputs from the non-granted port are ignored during ACCESS and DONE.
- Reset:
  - Asynchronous; an access in progress is aborted with no ack.
  - State = IDLE, lg = 1 (port 0 wins the first tie).
  - All outputs 0: mem_cs, mem_we, mem_addr, mem_wdata, m0/m1_rdata, m0/m1_ack, gnt, busy.
  - Release of reset takes effect on the next rising edge.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- With N = WAIT_CYCLES and the request sampled at edge E0:
  - mem_cs is high from E0 to E0+N (N cycles).
  - ack is high from E0+N to E0+N+1.
  - The state is back in IDLE after E0+N+1; sampling resumes at edge E0+N+2.
- Request-to-ack latency is N+1 cycles from the sampling edge.
- Minimum period for back-to-back accesses is N+2 cycles.
- gnt and busy are valid from E0 until E0+N+1.
- Under continuous contention, grants strictly alternate 0,1,0,1. A holding requester waits at most one full access (N+2 cycles) before it is granted.

## Test plan
- Reset, then hold both req low for 10 cycles -> all outputs stay 0, gnt=00, mem_cs never asserted.
- WAIT_CYCLES=1; m0 read addr 0x123, memory returns 0x5A5A -> mem_cs high 1 cycle with mem_addr=0x123 and mem_we=0; m0_ack pulses the next cycle with m0_rdata=0x5A5A; latency 2 cycles.
- WAIT_CYCLES=3; m1 write addr 0xFFF with data 0xBEEF -> mem_cs and mem_we high for exactly 3 cycles with mem_wdata=0xBEEF; then one m1_ack; m1_rdata unchanged.
- Both ports hold req after reset for 4 accesses -> gnt sequence 01,10,01,10; acks alternate m0,m1,m0,m1; each access takes WAIT_CYCLES+2 cycles.
- Assert reset in the second ACCESS cycle of a WAIT_CYCLES=3 access -> mem_cs and gnt drop to 0 immediately, no ack; after release with m1 requesting, m1 is granted.
- m0 keeps req high after its ack while m1 is idle -> back-to-back m0 accesses every WAIT_CYCLES+2 cycles; m1 rises mid-access -> m1 is granted next.
